// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
// It keeps its own shadow copy of the control information for the instructions
// in EX, MEM and WB. That copy is fed from the decoded ID-stage signals and
// advances with the pipeline. From the copy it derives:
//   - PC and IF/ID load enables (a freeze or a load-use stall drops them),
//   - IF/ID flush and ID/EX bubble insertion (taken branch, jump, load-use),
//   - EX operand forwarding selects,
//   - saturating debug counters for load-use stalls and flush events.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_rs/id_rt         ID source registers
//   id_uses_rs/rt       ID instruction actually reads rs/rt
//   id_dst              ID write register, taken after the RegDst mux
//   id_regwrite         ID RegWrite
//   id_memtoreg         ID MemtoReg (the instruction is a load)
//   id_jump             ID Jump
//   ex_branch_taken     branch in EX resolved taken
//   mem_stall           data memory not ready; freezes the whole pipeline
//   pc_write            PC load enable
//   ifid_write          IF/ID load enable
//   ifid_flush          clear IF/ID to a NOP at the next edge
//   idex_bubble         load NOP controls into ID/EX at the next edge
//   fwd_a/fwd_b         EX operand select: 00 regfile, 01 WB result,
//                       10 MEM ALU result
//   stall_cnt           load-use stall cycles (saturating)
//   flush_cnt           flush events (saturating)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_regwrite,
    input  logic             id_memtoreg,
    input  logic             id_jump,
    input  logic             ex_branch_taken,
    input  logic             mem_stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
    } entry_t;

    // Outcome of the per-cycle priority decision; the counters key off it.
    typedef enum logic [2:0] {
        DEC_RUN,
        DEC_FREEZE,
        DEC_BRANCH,
        DEC_LUSE,
        DEC_JUMP
    } decision_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    entry_t    ex_q, mem_q, wb_q;
    entry_t    id_entry;
    decision_e decision;
    logic      luse;

    assign id_entry = '{valid:    id_valid,
                        regwrite: id_regwrite,
                        memtoreg: id_memtoreg,
                        dst:      id_dst,
                        rs:       id_rs,
                        rt:       id_rt};

    // WB only needs valid/regwrite/dst for forwarding. The remaining fields
    // travel with the entry so that all three stages share one format.
    logic unused_wb_fields;
    assign unused_wb_fields = ^{wb_q.memtoreg, wb_q.rs, wb_q.rt};

    // A load in EX whose destination is read by the instruction in ID. Its
    // data exists only after MEM, so ID must wait one cycle. After that wait
    // the value is picked up from WB by the forwarding path.
    always_comb begin
        luse = id_valid & ex_q.valid & ex_q.memtoreg & (ex_q.dst != 5'd0) &
               ((id_uses_rs & (id_rs == ex_q.dst)) |
                (id_uses_rt & (id_rt == ex_q.dst)));
    end

    // NOTE: every output of this block gets a default before the priority
    // chain. Any path that skipped an assignment would otherwise infer a latch.
    always_comb begin
        decision    = DEC_RUN;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (mem_stall) begin
            decision   = DEC_FREEZE;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ex_branch_taken) begin
            // A load-use or jump in ID is moot: that instruction is squashed.
            decision    = DEC_BRANCH;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (luse) begin
            // A jump in ID is held here and re-evaluated next cycle.
            decision    = DEC_LUSE;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_valid && id_jump) begin
            decision   = DEC_JUMP;
            ifid_flush = 1'b1;
        end
    end

    // MEM beats WB because it holds the younger result. Only a non-load
    // result in MEM is available yet, and $0 is hard-wired, so it is never
    // forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input entry_t     mem_e,
                                           input entry_t     wb_e);
        if (mem_e.valid && mem_e.regwrite && !mem_e.memtoreg &&
            (mem_e.dst != 5'd0) && (mem_e.dst == src))
            return FWD_MEM;
        else if (wb_e.valid && wb_e.regwrite && (wb_e.dst != 5'd0) &&
                 (wb_e.dst == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ex_q.valid) begin
            fwd_a = fwd_sel(ex_q.rs, mem_q, wb_q);
            fwd_b = fwd_sel(ex_q.rt, mem_q, wb_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments. wb<=mem and
    // mem<=ex then all read the pre-edge values, like a real pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_stall) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            // A bubble is an all-zero entry: invalid, and it writes nothing.
            ex_q  <= idex_bubble ? '0 : id_entry;
        end
    end

    logic stall_evt, flush_evt;
    assign stall_evt = (decision == DEC_LUSE);
    assign flush_evt = (decision == DEC_BRANCH) || (decision == DEC_JUMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline scheduler for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Keeps its own shadow copy of the EX, MEM and WB stage control info, fed from the decoded ID-stage signals.
- From that copy it generates PC/IF-ID write enables, bubble insertion, flushes and EX-stage operand forwarding selects.
- Also keeps saturating stall and flush event counters for debug.

Parameters:
- CNT_W, 16, width of the stall/flush event counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_dst  in  5  ID resolved write register (after the RegDst mux).
- id_regwrite  in  1  ID RegWrite.
- id_memtoreg  in  1  ID MemtoReg (load).
- id_jump  in  1  ID Jump.
- ex_branch_taken  in  1  EX branch resolved taken (Branch & Zero).
- mem_stall  in  1  data memory not ready; freezes the whole pipeline.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP at the next edge.
- idex_bubble  out  1  load NOP controls into ID/EX at the next edge.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM ALU result.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  number of load-use stall cycles.
- flush_cnt  out  CNT_W  number of flush events.

Behaviour:
- Shadow entries ex/mem/wb, each holding {valid, regwrite, memtoreg, dst, rs, rt}.
- Reset (rst_n=0, asynchronous): all entry valid bits=0; counters=0.
- Outputs are combinational from the shadow entries and ID inputs. Right after reset, with no hazards: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00.
- Load-use hazard, luse:
  - Requires ex.valid & ex.memtoreg & ex.dst!=0.
  - And either (id_uses_rs & id_rs==ex.dst) or (id_uses_rt & id_rt==ex.dst).
  - Qualified by id_valid.
- Decision per cycle, in priority order:
  1. mem_stall=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0; shadow entries hold; counters hold.
  2. ex_branch_taken=1: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; flush_cnt+1. luse and jump are ignored because their instructions are squashed.
  3. luse=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; stall_cnt+1. A jump in ID is deferred and re-evaluated next cycle. Stall lasts exactly 1 cycle, because the load moves to MEM and is then forwarded.
  4. id_valid & id_jump: ifid_flush=1, pc_write=1, ifid_write=1; flush_cnt+1.
  5. Otherwise: pc_write=1, ifid_write=1, all others 0.
- Shadow advance on each edge unless mem_stall:
  - wb<=mem; mem<=ex.
  - ex<=ID info when idex_bubble=0, otherwise ex.valid<=0.
  - The ID info has valid=id_valid.
- Forwarding, evaluated for each of ex.rs→fwd_a and ex.rt→fwd_b:
  - 10 if mem.valid & mem.regwrite & !mem.memtoreg & mem.dst!=0 & mem.dst==src.
  - Else 01 if wb.valid & wb.regwrite & wb.dst!=0 & wb.dst==src.
  - Else 00.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
  - fwd_a and fwd_b are forced to 00 when ex.valid=0.
- Counters saturate at all-ones with no wrap.
- Reset mid-operation: all entries are invalidated immediately, with no pending stall/flush carried over.

Test Plan:
- Reset with rst_n=0 mid-run → entries invalid, counters 0. After release with no traffic: pc_write=1, fwd_a=fwd_b=00.
- lw $2 followed by add $3,$2,$4 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt=1. Next cycle fwd_a=01 (WB) for the add.
- add $2,.. ; add $5,$2,$2 → fwd_a=fwd_b=10 while the second add is in EX. Same sequence with $0 as destination → 00.
- add $2 ; add $2 ; sub $6,$2,$1 → fwd_a=10 (MEM wins over WB).
- Taken beq with ex_branch_taken=1 while lw/use is in ID → ifid_flush=1, idex_bubble=1, pc_write=1, flush_cnt+1, stall_cnt unchanged. Then j in ID → ifid_flush=1 for one cycle.
- mem_stall=1 for 3 cycles during a luse → all enables 0 and counters frozen. After release the luse stall occurs once: stall_cnt+1.
